tdc_meas_ctrl: RTL and testbench
================================

Name: tdc_meas_ctrl

Overview:
Measurement sequencer for the shift counter (scntr) time-to-digital path. On a start request it clears the counter, drives its input high for a programmed window, and snapshots the W-bit thermometer output. It then finds the thermometer length with a segmented multi-cycle priority scan and presents the binary code on a valid/ready interface. It sits between the ADPLL loop logic and the scntr instance.

Parameters:
W, 1024, scntr output width (thermometer length)
SEG, 64, bits scanned per encode cycle; W must be a multiple of SEG
WIN, 8, clock cycles o_cntr_in is held high (measurement window), >=1
CLR_CYC, 2, clock cycles o_cntr_rst is held high before arming, >=1

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  reset, asynchronous, active-high
i_start  input  1  measurement request; sampled only in IDLE
i_cntr_out  input  W  scntr o_out
o_cntr_rst  output  1  to scntr i_rst
o_cntr_in  output  1  to scntr i_in
o_busy  output  1  high in every state except IDLE
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result
o_code  output  $clog2(W)+1  thermometer length, 0..W
o_ovf  output  1  all W bits were ones (code==W)

Behaviour:
- Reset (async assert, sync release): state IDLE; o_cntr_rst=1, o_cntr_in=0, o_busy=0, o_valid=0, o_code=0, o_ovf=0, snapshot cleared.
- States: IDLE, CLR, ARM, RUN, CAP, ENC, DONE. All outputs registered.
- IDLE: o_cntr_rst=1. i_start=1 at edge N -> CLR.
- CLR: o_cntr_rst=1, o_cntr_in=0 for CLR_CYC cycles -> ARM.
- ARM: 1 cycle, o_cntr_rst=0, o_cntr_in=0 -> RUN.
- RUN: o_cntr_in=1 for exactly WIN cycles -> CAP.
- CAP: o_cntr_in=0; register i_cntr_out into snapshot; segment index k=0 -> ENC.
- ENC: one cycle per segment k (bits k*SEG .. k*SEG+SEG-1). If the segment contains a zero: code = k*SEG + index of lowest zero, ovf=0 -> DONE. Otherwise k++. After segment W/SEG-1 with no zero: code=W, ovf=1 -> DONE.
- Bits above the first zero are ignored (no error flag).
- DONE: o_valid=1, o_code/o_ovf stable until the i_ready=1 edge -> IDLE, o_valid=0 on the next cycle. o_code/o_ovf hold their last value in IDLE.
- Latency: o_valid rises at edge N+CLR_CYC+WIN+3+k, where k is the terminating segment (k=W/SEG-1 for overflow).
- i_start outside IDLE is ignored and not queued. i_start and i_ready both high in DONE: return to IDLE only; no new measurement starts.
- Async reset in any state: immediate return to reset values; an in-flight result is discarded.
- i_cntr_out is sampled only in CAP; changes elsewhere have no effect.

Optional Feature:
TDC_BUBBLE_FIX_EN: when defined, the termination is the lowest index i where bits i and i+1 are both zero. Bit W is treated as 0. Lookahead crosses segment boundaries, which suppresses single-bit bubbles. When undefined, the termination is the lowest zero bit. Latency and the state sequence are identical in both builds.

Test Plan:
Common settings: W=1024, SEG=64, WIN=8, CLR_CYC=2.
1. Assert i_rst mid-stream -> immediately o_cntr_rst=1, o_cntr_in=0, o_busy=0, o_valid=0, o_code=0, o_ovf=0.
2. Start at edge N, i_cntr_out=37 low ones -> o_cntr_rst high 2 cycles, o_cntr_in high exactly 8 cycles; o_valid at N+13, o_code=37, o_ovf=0.
3. i_cntr_out=700 low ones -> o_valid at N+23, o_code=700; all ones -> o_valid at N+28, o_code=1024, o_ovf=1.
4. Hold i_ready=0 for 5 cycles in DONE and pulse i_start -> o_code stable and o_busy=1 throughout; IDLE after i_ready; the second start causes no measurement.
5. Assert i_rst during RUN -> o_cntr_in drops immediately and no o_valid follows; a fresh start then completes normally.
6. Ones at bits 0..99 with bit 50 cleared -> o_code=50 without TDC_BUBBLE_FIX_EN, o_code=100 with it.

Source files
------------

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the scntr TDC: clear, arm, run a window, snapshot, segmented thermometer encode.
// Optional build macro TDC_BUBBLE_FIX_EN: terminate on the first pair of adjacent zeros instead of the first zero.
module tdc_meas_ctrl #(
  parameter int W       = 1024,
  parameter int SEG     = 64,
  parameter int WIN     = 8,
  parameter int CLR_CYC = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [W-1:0]       i_cntr_out,
  output logic               o_cntr_rst,
  output logic               o_cntr_in,
  output logic               o_busy,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [$clog2(W):0] o_code,
  output logic               o_ovf
);

  localparam int NSEG = W / SEG;
  localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int IW   = (SEG > 1) ? $clog2(SEG) : 1;
  localparam int CW   = $clog2(W) + 1;
  localparam int TMAX = (WIN > CLR_CYC) ? WIN : CLR_CYC;
  localparam int TW   = $clog2(TMAX) + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_CAP  = 3'd4,
    ST_ENC  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [TW-1:0]   tmr_r;
  logic [KW-1:0]   k_r;
  logic [W-1:0]    snap_r;
  logic [CW-1:0]   code_r;
  logic            ovf_r;
  logic            cntr_rst_r, cntr_in_r, busy_r, valid_r;
  logic            cntr_rst_s, cntr_in_s, busy_s, valid_s;
  logic [SEG-1:0]  mask_s;
  logic            found_s;
  logic [IW-1:0]   idx_s;
  logic            last_seg_s;
  logic [CW-1:0]   enc_code_s;

  function automatic logic [IW-1:0] lowest_set(input logic [SEG-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = SEG - 1; i >= 0; i--) begin
      if (v[i]) idx = IW'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

`ifdef TDC_BUBBLE_FIX_EN
  // Each segment carries one lookahead bit from the next segment; bit W reads as zero.
  logic [W:0]   ext_s;
  logic [SEG:0] segs_s [NSEG];

  function automatic logic [SEG-1:0] term_mask(input logic [SEG:0] b);
    logic [SEG-1:0] m;
    for (int i = 0; i < SEG; i++) m[i] = ~b[i] & ~b[i+1];
    return m;
  endfunction

  assign ext_s = {1'b0, snap_r};
  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    assign segs_s[g] = ext_s[g*SEG +: SEG+1];
  end
`else
  logic [SEG-1:0] segs_s [NSEG];

  function automatic logic [SEG-1:0] term_mask(input logic [SEG-1:0] b);
    return ~b;
  endfunction

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    assign segs_s[g] = snap_r[g*SEG +: SEG];
  end
`endif

  // Segment encoder: termination mask of the current segment and its lowest hit.
  always_comb begin
    mask_s     = term_mask(segs_s[k_r]);
    found_s    = |mask_s;
    idx_s      = lowest_set(mask_s);
    last_seg_s = (k_r == KW'(NSEG - 1));
    enc_code_s = CW'(k_r) * CW'(SEG) + CW'(idx_s);
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_r <= ST_IDLE;
    else       state_r <= state_nx_s;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) state_nx_s = ST_CLR;
        else         state_nx_s = ST_IDLE;
      end
      ST_CLR: begin
        if (tmr_r == TW'(CLR_CYC - 1)) state_nx_s = ST_ARM;
        else                           state_nx_s = ST_CLR;
      end
      ST_ARM:  state_nx_s = ST_RUN;
      ST_RUN: begin
        if (tmr_r == TW'(WIN - 1)) state_nx_s = ST_CAP;
        else                       state_nx_s = ST_RUN;
      end
      ST_CAP:  state_nx_s = ST_ENC;
      ST_ENC: begin
        if (found_s || last_seg_s) state_nx_s = ST_DONE;
        else                       state_nx_s = ST_ENC;
      end
      ST_DONE: begin
        if (i_ready) state_nx_s = ST_IDLE;
        else         state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs track the state exactly.
  always_comb begin
    cntr_rst_s = 1'b0;
    cntr_in_s  = 1'b0;
    busy_s     = 1'b1;
    valid_s    = 1'b0;
    case (state_nx_s)
      ST_IDLE: begin cntr_rst_s = 1'b1; busy_s = 1'b0; end
      ST_CLR:  cntr_rst_s = 1'b1;
      ST_RUN:  cntr_in_s  = 1'b1;
      ST_DONE: valid_s    = 1'b1;
      default: begin cntr_rst_s = 1'b0; cntr_in_s = 1'b0; end
    endcase
  end

  // Output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cntr_rst_r <= 1'b1;
      cntr_in_r  <= 1'b0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      cntr_rst_r <= cntr_rst_s;
      cntr_in_r  <= cntr_in_s;
      busy_r     <= busy_s;
      valid_r    <= valid_s;
    end
  end

  // Datapath: phase timer, segment index, snapshot and result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmr_r  <= '0;
      k_r    <= '0;
      snap_r <= '0;
      code_r <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (state_nx_s != state_r) tmr_r <= '0;
      else if ((state_r == ST_CLR) || (state_r == ST_RUN)) tmr_r <= tmr_r + 1'b1;
      else tmr_r <= tmr_r;

      if (state_r == ST_CAP) begin
        snap_r <= i_cntr_out;
        k_r    <= '0;
      end else if (state_r == ST_ENC) begin
        k_r    <= k_r + 1'b1;
      end else begin
        k_r    <= k_r;
      end

      if ((state_r == ST_ENC) && (found_s || last_seg_s)) begin
        code_r <= found_s ? enc_code_s : CW'(W);
        ovf_r  <= ~found_s;
      end else begin
        code_r <= code_r;
        ovf_r  <= ovf_r;
      end
    end
  end

  assign o_cntr_rst = cntr_rst_r;
  assign o_cntr_in  = cntr_in_r;
  assign o_busy     = busy_r;
  assign o_valid    = valid_r;
  assign o_code     = code_r;
  assign o_ovf      = ovf_r;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed table-driven bench for tdc_meas_ctrl plus hand-written DONE-hold and mid-run reset sequences.
module tb_tdc_meas_ctrl;

  localparam int W = 1024, SEG = 64, WIN = 8, CLR_CYC = 2;

  logic            clk = 1'b0;
  logic            i_rst;
  logic            i_start;
  logic [W-1:0]    i_cntr_out;
  logic            o_cntr_rst, o_cntr_in, o_busy, o_valid;
  logic            i_ready;
  logic [10:0]     o_code;
  logic            o_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ones;
    int clr;
    int code;
    int ovf;
    int lat;
  } vec_t;

  vec_t vecs [8];

  tdc_meas_ctrl #(.W(W), .SEG(SEG), .WIN(WIN), .CLR_CYC(CLR_CYC)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_cntr_out(i_cntr_out),
    .o_cntr_rst(o_cntr_rst), .o_cntr_in(o_cntr_in), .o_busy(o_busy), .o_valid(o_valid),
    .i_ready(i_ready), .o_code(o_code), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cntr_rst"}, int'(o_cntr_rst), 1);
    chk({tag, "_cntr_in"},  int'(o_cntr_in), 0);
    chk({tag, "_busy"},     int'(o_busy), 0);
    chk({tag, "_valid"},    int'(o_valid), 0);
    chk({tag, "_code"},     int'(o_code), 0);
    chk({tag, "_ovf"},      int'(o_ovf), 0);
  endtask

  function automatic logic [W-1:0] mk_pat(input int ones, input int clr);
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < ones; i++) p[i] = 1'b1;
    if (clr >= 0) p[clr] = 1'b0;
    return p;
  endfunction

  // Start at edge N, count edges to o_valid and the cycles rst/in were high.
  task automatic run_meas(input logic [W-1:0] pat, input bit accept,
                          output int lat, output int in_hi, output int rst_hi);
    @(negedge clk);
    i_cntr_out = pat;
    i_start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    lat = 0; in_hi = 0; rst_hi = 0;
    in_hi  += int'(o_cntr_in);
    rst_hi += int'(o_cntr_rst);
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      @(negedge clk);
      lat = c;
      if (o_valid) break;
      in_hi  += int'(o_cntr_in);
      rst_hi += int'(o_cntr_rst);
    end
    chk("valid_seen", int'(o_valid), 1);
    chk("busy_in_done", int'(o_busy), 1);
    if (accept) begin
      i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_ready = 1'b0;
      chk("valid_after_ready", int'(o_valid), 0);
      chk("busy_after_ready", int'(o_busy), 0);
    end
  endtask

  initial begin
    int lat, in_hi, rst_hi, busy_seen, valid_seen;

    vecs[0] = '{ones: 37,   clr: -1, code: 37,   ovf: 0, lat: 13};
    vecs[1] = '{ones: 700,  clr: -1, code: 700,  ovf: 0, lat: 23};
    vecs[2] = '{ones: 1024, clr: -1, code: 1024, ovf: 1, lat: 28};
    vecs[3] = '{ones: 0,    clr: -1, code: 0,    ovf: 0, lat: 13};
    vecs[4] = '{ones: 63,   clr: -1, code: 63,   ovf: 0, lat: 13};
    vecs[5] = '{ones: 64,   clr: -1, code: 64,   ovf: 0, lat: 14};
    vecs[6] = '{ones: 1023, clr: -1, code: 1023, ovf: 0, lat: 28};
`ifdef TDC_BUBBLE_FIX_EN
    vecs[7] = '{ones: 100,  clr: 50, code: 100,  ovf: 0, lat: 14};
`else
    vecs[7] = '{ones: 100,  clr: 50, code: 50,   ovf: 0, lat: 13};
`endif

    i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b0; i_cntr_out = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    i_rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      run_meas(mk_pat(vecs[v].ones, vecs[v].clr), 1'b1, lat, in_hi, rst_hi);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_in_cycles", v), in_hi, WIN);
      chk($sformatf("v%0d_rst_cycles", v), rst_hi, CLR_CYC);
      chk($sformatf("v%0d_code", v), int'(o_code), vecs[v].code);
      chk($sformatf("v%0d_ovf", v), int'(o_ovf), vecs[v].ovf);
    end

    // DONE hold with i_ready low, a stray start and a changing counter input.
    run_meas(mk_pat(700, -1), 1'b0, lat, in_hi, rst_hi);
    chk("hold_latency", lat, 23);
    for (int c = 0; c < 5; c++) begin
      i_start    = (c == 2);
      i_cntr_out = '0;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", int'(o_valid), 1);
      chk("hold_busy", int'(o_busy), 1);
      chk("hold_code", int'(o_code), 700);
    end
    i_start = 1'b1; i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0; i_ready = 1'b0;
    chk("hold_exit_valid", int'(o_valid), 0);
    chk("hold_exit_busy", int'(o_busy), 0);
    chk("hold_exit_code", int'(o_code), 700);
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      busy_seen += int'(o_busy);
    end
    chk("no_queued_start", busy_seen, 0);

    // Reset asserted while the window is open.
    i_cntr_out = mk_pat(37, -1);
    i_start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("run_in_before_rst", int'(o_cntr_in), 1);
    #2 i_rst = 1'b1;
    #1 chk_reset_vals("midrun");
    @(negedge clk);
    i_rst = 1'b0;
    valid_seen = 0;
    repeat (40) begin
      @(negedge clk);
      valid_seen += int'(o_valid);
    end
    chk("no_valid_after_rst", valid_seen, 0);
    run_meas(mk_pat(37, -1), 1'b1, lat, in_hi, rst_hi);
    chk("post_rst_latency", lat, 13);
    chk("post_rst_code", int'(o_code), 37);
    chk("post_rst_in_cycles", in_hi, WIN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
